vram_scheduler: RTL and testbench
=================================

# vram_scheduler

Shares one single-port synchronous video RAM between display scan-out and CPU accesses. Display byte fetches go in fixed slots locked to the VGA timing generator's counters and always take priority. The CPU gets every other RAM cycle through a req/ack handshake. The block serialises fetched bytes into a 1-bpp pixel stream and delays the sync signals by one cycle so they stay aligned with that stream.

## Interface
- `H_START`, 80: first visible column of the 480-pixel window.
- `BYTES_PER_LINE`, 60: bytes per framebuffer row (8 pixels per byte, MSB first).
- `LINES`, 480: framebuffer rows.
- `H_TOTAL`, 800: clocks per line.
- `V_TOTAL`, 525: lines per frame.
- `clk`  in  1  pixel clock, shared with the timing generator.
- `rst_n`  in  1  asynchronous active-low reset.
- `pixel_x`, `pixel_y`  in  10 each  timing-generator counters for the current cycle.
- `video_active`, `hsync_in`, `vsync_in`  in  1 each  timing-generator outputs for the current cycle.
- `cpu_req`  in  1  access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; held with `cpu_req`.
- `cpu_addr`  in  15  byte address; held with `cpu_req`.
- `cpu_wdata`  in  8  write data; held with `cpu_req`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data; valid only in the `cpu_ack` cycle.
- `ram_en`, `ram_we`  out  1 each  RAM strobes, combinational.
- `ram_addr`  out  15  RAM address, combinational.
- `ram_wdata`  out  8  RAM write data, combinational.
- `ram_rdata`  in  8  RAM read data, valid one cycle after `ram_en`.
- `pixel_on`  out  1  registered pixel value.
- `hsync_out`, `vsync_out`, `active_out`  out  1 each  inputs delayed one cycle.

## Operation
- **Fetch slot**
  - Defined as `pixel_y < LINES` and `pixel_x == H_START-8+8g`, for g = 0..59.
  - Drive `ram_en=1`, `ram_we=0`, `ram_addr = line_base + g`.
- **line_base register (15 bits)**
  - Reset value: 0.
  - At `pixel_x == H_TOTAL-1`: if `pixel_y == V_TOTAL-1`, set to 0; else if `pixel_y < LINES-1`, add 60; otherwise hold.
  - No multiplier is used.
- **Fetch capture.** In the cycle after a fetch slot, `ram_rdata` is latched into `fetch_buf`.
- **Shifter**
  - Load cycle is `pixel_x == H_START+8g`, g = 0..59, with `pixel_y < LINES`.
  - On a load cycle: `pixel_on <= fetch_buf[7]`, `sr <= {fetch_buf[6:0], 0}`.
  - Otherwise: `pixel_on <= sr[7]`, `sr <= sr << 1`.
  - `pixel_on` is forced to 0 whenever `video_active` is 0.
- **CPU arbitration**
  - State is IDLE or ACK.
  - IDLE with `cpu_req` in a non-fetch-slot cycle is a grant: drive `ram_en=1`, `ram_we=cpu_we`, `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`; go to ACK.
  - ACK: `cpu_ack=1`, `cpu_rdata=ram_rdata` (registered pass-through is not allowed; drive it combinationally from `ram_rdata`); return to IDLE. No grant is made in the ACK cycle.
  - `cpu_req` in a fetch-slot cycle: the fetch wins. The next cycle is never a fetch slot, so the CPU is granted then.
- **Address range.** All addresses reach the RAM; 28800..32767 are ordinary off-screen storage.
- **Reset**
  - `pixel_on`, `hsync_out`, `vsync_out`, `active_out`, `cpu_ack` = 0; `sr`, `fetch_buf`, `line_base` = 0; state = IDLE.
  - A request granted when reset asserts is abandoned with no ack. A write may already have been performed by the RAM.

## Timing
- **Pixel latency.** `pixel_on` at cycle t+1 shows the pixel for `pixel_x`/`pixel_y` sampled at cycle t. The sync and active outputs carry the same one-cycle delay.
- **Fetch lead.** The byte for group g is read 8 cycles before display and captured 7 cycles before the load.
- **CPU latency**
  - Request seen in IDLE, no conflict: ack the next cycle, 1 cycle.
  - Request collides with a fetch slot: 2 cycles.
  - Maximum sustained CPU bandwidth: one access per 2 cycles.
  - The CPU drops `cpu_req` or changes the address in the cycle after `cpu_ack`. A request still high then is a new access.
- **Vertical blanking.** No fetch slots exist in rows 480..524 or in columns outside 72..551 of the fetch pattern. In those regions the CPU is never delayed.

## Test plan
- **Reset.** Hold `rst_n=0` for 5 cycles with random inputs -> all outputs 0 and `ram_en=0`. Release -> `line_base` is 0 at the first slot (x=72, y=0).
- **Row fetch.** Preload RAM[60]=8'hA5 and run to y=1 -> `ram_addr=60` at x=72. Then `pixel_on` over cycles x=81..88 is 1,0,1,0,0,1,0,1.
- **Last row and frame wrap.** At y=479 the slot at x=544 reads address 28799. No `ram_en` from fetch logic during y=480..524. At y=0 of the next frame, x=72 reads address 0.
- **CPU write.** Write with `cpu_req` at x=200 (not a slot) -> `ram_we=1` at x=200 and `cpu_ack` at x=201. A read-back after that returns the written byte with its ack.
- **Collision.** `cpu_req` (read) first high at x=152, a slot -> fetch drives `ram_addr`. CPU grant at x=153, ack at x=154 with the correct `cpu_rdata`.
- **Back-to-back and reset mid-access.** Hold `cpu_req` high for 10 cycles -> acks on alternate cycles. Assert `rst_n=0` in a grant cycle -> no ack is issued.

Source files
------------

// File: rtl/vram_scheduler_if.sv
// Bus bundle for the video RAM scheduler: CPU request port and RAM port.
//
// Handshake: cpu_req is raised with cpu_we/cpu_addr/cpu_wdata and held
// unchanged until the single-cycle cpu_ack pulse; cpu_rdata is meaningful
// only in that ack cycle. A request still high in the cycle after cpu_ack
// is a new access. The RAM port is a plain single-port synchronous RAM:
// strobes and address apply in the current cycle, ram_rdata returns one
// cycle after ram_en.
interface vram_scheduler_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   // Scheduler side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

   // Environment side: the CPU and the RAM together
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vram_scheduler.sv
// Video RAM scheduler: display byte fetches in fixed slots locked to the
// VGA counters, CPU accesses in the remaining cycles, and a 1-bpp pixel
// serialiser with sync signals delayed to stay aligned with the pixels.
module vram_scheduler #(
   parameter int H_START        = 80,
   parameter int BYTES_PER_LINE = 60,
   parameter int LINES          = 480,
   parameter int H_TOTAL        = 800,
   parameter int V_TOTAL        = 525
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       pixel_x,
   input  logic [9:0]       pixel_y,
   input  logic             video_active,
   input  logic             hsync_in,
   input  logic             vsync_in,
   vram_scheduler_if.slave  bus,
   output logic             pixel_on,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             active_out,
   output logic [0:0]       dbg_state_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   // Fetch for group g runs 8 clocks ahead of that group's first pixel.
   localparam int FETCH_FIRST = H_START - 8;
   localparam int FETCH_LAST  = H_START - 8 + 8 * (BYTES_PER_LINE - 1);
   localparam int LOAD_LAST   = H_START + 8 * (BYTES_PER_LINE - 1);

   logic [0:0]  state_q, state_d;
   logic [14:0] line_base_q, line_base_d;
   logic        fetch_q;
   logic [7:0]  fetch_buf_q;
   logic [7:0]  sr_q;
   logic        pixel_on_q, hsync_q, vsync_q, active_q;

   logic        in_rows;
   logic [9:0]  fetch_off;
   logic [6:0]  fetch_group;
   logic        fetch_slot;
   logic [2:0]  load_phase;
   logic        load_cycle;
   logic        grant;
   logic [14:0] fetch_addr;

   assign in_rows     = pixel_y < 10'(LINES);
   assign fetch_off   = pixel_x - 10'(FETCH_FIRST);
   assign fetch_group = fetch_off[9:3];
   assign fetch_slot  = in_rows && (pixel_x >= 10'(FETCH_FIRST)) &&
                        (pixel_x <= 10'(FETCH_LAST)) && (fetch_off[2:0] == 3'd0);
   assign fetch_addr  = line_base_q + {8'd0, fetch_group};

   assign load_phase  = pixel_x[2:0] - H_START[2:0];
   assign load_cycle  = in_rows && (pixel_x >= 10'(H_START)) &&
                        (pixel_x <= 10'(LOAD_LAST)) && (load_phase == 3'd0);

   // The CPU only gets the RAM in idle, non-fetch cycles; the ack cycle never grants.
   assign grant = rst_n && (state_q == ST_IDLE) && bus.cpu_req && !fetch_slot;

   // RAM port mux: fetch wins, otherwise a granted CPU access; silent in reset.
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (rst_n) begin
         if (fetch_slot) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = fetch_addr;
         end else if (grant) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
         end
      end
   end

   // CPU handshake outputs: read data passes straight through from the RAM.
   always_comb begin
      bus.cpu_ack   = (state_q == ST_ACK);
      bus.cpu_rdata = (state_q == ST_ACK) ? bus.ram_rdata : 8'h00;
   end

   // Arbitration FSM next state: a grant always leads to exactly one ack cycle.
   always_comb begin
      state_d = ST_IDLE;
      if ((state_q == ST_IDLE) && grant) state_d = ST_ACK;
   end

   // Row base address: stepped by one row per line, rewound at frame end.
   always_comb begin
      line_base_d = line_base_q;
      if (pixel_x == 10'(H_TOTAL - 1)) begin
         if (pixel_y == 10'(V_TOTAL - 1))    line_base_d = '0;
         else if (pixel_y < 10'(LINES - 1))  line_base_d = line_base_q + 15'(BYTES_PER_LINE);
      end
   end

   // Control state: FSM, row base and the fetch-capture flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         line_base_q <= '0;
         fetch_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_base_q <= line_base_d;
         fetch_q     <= fetch_slot;
      end
   end

   // Capture the fetched byte in the cycle after its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       fetch_buf_q <= '0;
      else if (fetch_q) fetch_buf_q <= bus.ram_rdata;
   end

   // Pixel serialiser, MSB first, blanked outside the active window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q       <= '0;
         pixel_on_q <= 1'b0;
      end else if (load_cycle) begin
         sr_q       <= {fetch_buf_q[6:0], 1'b0};
         pixel_on_q <= video_active & fetch_buf_q[7];
      end else begin
         sr_q       <= {sr_q[6:0], 1'b0};
         pixel_on_q <= video_active & sr_q[7];
      end
   end

   // Sync and active delayed one cycle to line up with pixel_on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         hsync_q  <= hsync_in;
         vsync_q  <= vsync_in;
         active_q <= video_active;
      end
   end

   assign pixel_on    = pixel_on_q;
   assign hsync_out   = hsync_q;
   assign vsync_out   = vsync_q;
   assign active_out  = active_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: drives VGA counters and a CPU, models the RAM,
// and checks pixels, fetch addresses and CPU transactions against a
// frame-level reference built from the row/column arithmetic.
module tb_vram_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_active, hsync_in, vsync_in;
   logic        pixel_on, hsync_out, vsync_out, active_out;
   logic [0:0]  dbg_state;

   vram_scheduler_if bus();

   vram_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .video_active (video_active),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .bus          (bus),
      .pixel_on     (pixel_on),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .active_out   (active_out),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- RAM model and reference memory ----------------
   logic [7:0] ram     [0:32767];
   logic [7:0] ref_mem [0:32767];
   bit         ram_loaded;

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 32768; i++) ram[i] <= ref_mem[i];
         ram_loaded <= 1'b1;
      end else if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= ram[bus.ram_addr];
      end
   end

   // ---------------- scoreboard state ----------------
   int         tests = 0;
   int         fails = 0;
   logic [8:0] exp_q[$];      // {is_write, expected read data}
   int         cur_x = 0, cur_y = 0;
   bit         seq_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)",
                  name, got, exp, pixel_x, pixel_y, $time);
      end
   endtask

   // Fetch slot rule: 60 slots per visible row, 8 clocks ahead of each byte.
   function automatic bit is_slot(input int x, input int y);
      return (y < 480) && (x >= 72) && (x <= 544) && ((x - 72) % 8 == 0);
   endfunction

   // Expected displayed pixel for counters (x,y): framebuffer bit, MSB first.
   function automatic logic pix_model(input int x, input int y, input logic act);
      int off;
      logic [7:0] b;
      if (!act || y >= 480 || x < 80 || x >= 560) return 1'b0;
      off = x - 80;
      b = ref_mem[y * 60 + off / 8];
      return b[7 - (off % 8)];
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_xy(input int x, input int y);
      cur_x = x;
      cur_y = y;
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      video_active = (y < 480) && (x >= 80) && (x < 560);
      hsync_in = (x >= 656) && (x < 752);
      vsync_in = (y == 490) || (y == 491);
   endtask

   task automatic set_xy(input int x, input int y);
      @(posedge clk);
      #1;
      drive_xy(x, y);
   endtask

   task automatic run_line(input int y, input bit full);
      if (full) for (int x = 0; x < 800; x++) set_xy(x, y);
      else set_xy(799, y);
   endtask

   task automatic counter_seq();
      run_line(0, 1);
      run_line(1, 1);
      for (int y = 2; y <= 478; y++) run_line(y, 0);
      run_line(479, 1);
      run_line(480, 1);
      for (int y = 481; y <= 523; y++) run_line(y, 0);
      run_line(524, 1);
      run_line(0, 1);
      run_line(1, 1);
      seq_done = 1'b1;
   endtask

   // Issue one CPU access at the current cycle (called at posedge+2) and wait for its ack.
   task automatic cpu_access(input bit we, input logic [14:0] addr, input logic [7:0] wdata);
      int  exp_lat;
      int  n;
      bit  got;
      exp_lat = is_slot(cur_x, cur_y) ? 2 : 1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      exp_q.push_back({we, we ? 8'h00 : ref_mem[addr]});
      if (we) ref_mem[addr] = wdata;
      got = 1'b0;
      n = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         if (n == exp_lat - 1) begin
            chk("grant_en", 32'(bus.ram_en), 32'd1);
            chk("grant_we", 32'(bus.ram_we), 32'(we));
            chk("grant_addr", 32'(bus.ram_addr), 32'(addr));
            if (we) chk("grant_wdata", 32'(bus.ram_wdata), 32'(wdata));
         end
         if (bus.cpu_ack) got = 1'b1;
         else n++;
      end
      chk("cpu_latency", 32'(n), 32'(exp_lat));
      @(posedge clk);
      #2;
   endtask

   task automatic cpu_idle(input int cycles);
      bus.cpu_req = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_xy(input int x, input int y);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 20000 && !hit; k++) begin
         if (cur_x == x && cur_y == y) hit = 1'b1;
         else begin
            @(posedge clk);
            #2;
         end
      end
      chk("wait_xy_reached", 32'(hit), 32'd1);
   endtask

   task automatic cpu_seq();
      logic [14:0] a;
      logic [7:0]  d;
      bit          we;
      // Read colliding with the x=152 fetch slot of row 1
      wait_xy(152, 1);
      cpu_access(1'b0, 15'd60, 8'h00);
      cpu_idle(1);
      // Write in blanking, immediate read-back, then a back-to-back read burst
      wait_xy(200, 480);
      a = 15'($urandom_range(28800, 32767));
      d = 8'($urandom);
      cpu_access(1'b1, a, d);
      cpu_access(1'b0, a, 8'h00);
      for (int i = 0; i < 4; i++) cpu_access(1'b0, 15'($urandom_range(0, 32767)), 8'h00);
      cpu_idle(1);
      // Random traffic; writes only in vertical blanking so displayed rows stay stable
      while (!seq_done) begin
         cpu_idle($urandom_range(0, 3));
         if (!seq_done) begin
            we = (cur_y >= 480) && ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 119))
                                           : 15'($urandom_range(0, 32767));
            cpu_access(we, a, 8'($urandom));
         end
      end
      bus.cpu_req = 1'b0;
   endtask

   // ---------------- monitor ----------------
   task automatic monitor();
      bit    prev_ok;
      logic  exp_pix, p_h, p_v, p_a;
      logic [8:0] e;
      int    x, y;
      prev_ok = 1'b0;
      exp_pix = 1'b0; p_h = 1'b0; p_v = 1'b0; p_a = 1'b0;
      forever begin
         @(negedge clk);
         x = int'(pixel_x);
         y = int'(pixel_y);
         if (!rst_n) begin
            chk("rst_pixel_on", 32'(pixel_on), 32'd0);
            chk("rst_hsync_out", 32'(hsync_out), 32'd0);
            chk("rst_vsync_out", 32'(vsync_out), 32'd0);
            chk("rst_active_out", 32'(active_out), 32'd0);
            chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
            chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
            prev_ok = 1'b0;
         end else begin
            if (prev_ok) begin
               chk("pixel_on", 32'(pixel_on), 32'(exp_pix));
               chk("hsync_out", 32'(hsync_out), 32'(p_h));
               chk("vsync_out", 32'(vsync_out), 32'(p_v));
               chk("active_out", 32'(active_out), 32'(p_a));
            end
            if (is_slot(x, y)) begin
               chk("fetch_en", 32'(bus.ram_en), 32'd1);
               chk("fetch_we", 32'(bus.ram_we), 32'd0);
               chk("fetch_addr", 32'(bus.ram_addr), 32'(y * 60 + (x - 72) / 8));
            end else if (!bus.cpu_req) begin
               chk("idle_ram_en", 32'(bus.ram_en), 32'd0);
            end
            if (bus.cpu_ack) begin
               if (exp_q.size() == 0) begin
                  chk("ack_expected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  if (!e[8]) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e[7:0]));
               end
            end
            exp_pix = pix_model(x, y, video_active);
            p_h = hsync_in;
            p_v = vsync_in;
            p_a = video_active;
            prev_ok = 1'b1;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      drive_xy(0, 0);
      bus.cpu_req = 1'b0;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_wdata = '0;
      for (int i = 0; i < 32768; i++) ref_mem[i] = 8'($urandom);
      ref_mem[60] = 8'hA5;

      fork
         monitor();
      join_none

      // Reset held with random inputs
      repeat (5) begin
         @(posedge clk);
         #1;
         pixel_x = 10'($urandom_range(0, 799));
         pixel_y = 10'($urandom_range(0, 524));
         video_active = 1'($urandom);
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         bus.cpu_req = 1'($urandom);
         bus.cpu_we = 1'($urandom);
         bus.cpu_addr = 15'($urandom);
         bus.cpu_wdata = 8'($urandom);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.cpu_req = 1'b0;
      drive_xy(0, 0);

      fork
         counter_seq();
         cpu_seq();
      join

      // Reset asserted in the middle of a grant cycle: the access is abandoned
      @(posedge clk);
      #1;
      drive_xy(300, 490);
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = 15'd5;
      @(negedge clk);
      chk("rst_mid_grant_en", 32'(bus.ram_en), 32'd1);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_no_ack", 32'(bus.cpu_ack), 32'd0);
      end
      chk("rst_mid_state_idle", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Display restarts cleanly from row 0
      run_line(0, 1);
      repeat (4) @(posedge clk);
      chk("pending_acks", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
